ysyx_22050854_fetch_ctrl: RTL and testbench
===========================================

Name: ysyx_22050854_fetch_ctrl

Overview:
- Fetch sequencer that owns the architectural fetch PC and drives the instruction-memory request/response handshake.
- Delivers {pc, inst} to the IF/ID stage over valid/ready.
- Accepts redirects from the PC/branch unit (jump target) and the CSR unit (ecall/mret target).
- Keeps at most one fetch outstanding and squashes any fetch made stale by a redirect.

Parameters:
RESET_PC, 32'h80000000, PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
br_redirect  in  1  branch/jump taken this cycle (the PC unit's jump)
br_target  in  32  branch/jump target (the PC unit's next_pc)
trap_redirect  in  1  ecall/mret redirect (is_csr_pc)
trap_target  in  32  CSR-supplied target (csr_pc)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address
imem_resp_valid  in  1  response valid
imem_resp_data  in  32  fetched instruction
imem_resp_ready  out  1  controller accepts response
inst_valid  out  1  instruction available to IF/ID
inst_ready  in  1  IF/ID consumes instruction
inst_pc  out  32  PC of delivered instruction
inst  out  32  delivered instruction
fetch_pc  out  32  current fetch PC (debug)

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, fetch_pc=RESET_PC, drop=0.
  - imem_req_valid=0, imem_resp_ready=0, inst_valid=0.
  - inst_pc=0, inst=0.
- All outputs are registered or decoded from state only (Moore); no comb path from inputs to outputs.
- States and transitions:
  - IDLE: unconditionally -> REQ on the next clock.
  - REQ: imem_req_valid=1, imem_req_addr=fetch_pc. On req_valid&req_ready -> WAIT.
  - WAIT: imem_resp_ready=1. On resp_valid:
    - drop=0: capture resp_data into inst and fetch_pc into inst_pc -> HOLD.
    - drop=1: discard, clear drop -> REQ.
  - HOLD: inst_valid=1. On inst_ready: fetch_pc <= fetch_pc+PC_STEP (mod 2^32) -> REQ.
- Latency: response captured in the cycle after resp_valid. Minimum 3 cycles per instruction (REQ, WAIT, HOLD), assuming single-cycle ready.
- Redirect select:
  - trap_redirect has priority over br_redirect; target = trap_target if trap_redirect, else br_target.
  - Redirect is sampled in every state except IDLE. In IDLE, redirects are ignored.
- Effect of an accepted redirect, by state:
  - REQ, handshake not completing: fetch_pc <= target; stay REQ. The address changes only on redirect; imem tolerates a request abort.
  - REQ, handshake completing the same cycle: fetch_pc <= target, drop <= 1 -> WAIT.
  - WAIT, no resp_valid this cycle: fetch_pc <= target, drop <= 1; stay WAIT.
  - WAIT, resp_valid the same cycle: discard the response -> REQ.
  - HOLD, no inst_ready: buffered instruction is squashed, inst_valid drops next cycle, fetch_pc <= target -> REQ.
  - HOLD, inst_ready the same cycle: the instruction is handed off, fetch_pc <= target (not +4) -> REQ.
- A second redirect while drop=1 only updates fetch_pc; drop stays 1, so only one response is discarded.
- Reset mid-transaction: immediate return to IDLE. imem is reset by the same reset, so no stale response may arrive.

Optional Feature:
- Macro: YSYX_22050854_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt (64) and perf_drop_cnt (64). Both reset to 0.
  - perf_fetch_cnt increments on each inst_valid&inst_ready.
  - perf_drop_cnt increments on each discarded response and each squashed HOLD instruction.
  - Counters wrap at 2^64.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ysyx_22050854_fetch_pkg holds:
  - fetch state enum (IDLE, REQ, WAIT, HOLD), 2 bits.
  - RESET_PC default constant.
  - PC width constant (32).
- One sub-module, ysyx_22050854_redirect_sel: combinational trap-over-branch priority select that outputs redirect valid and target.
- The FSM stays in the top block.

Test Plan:
- Reset release, imem ready=1, 1-cycle response 32'h00000413, inst_ready=1 -> first imem_req_addr=32'h80000000; inst_valid with inst_pc=80000000, inst=00000413; next request addr 80000004.
- Branch redirect to 32'h80000100 in WAIT, response arrives 2 cycles later -> response discarded, inst_valid stays 0, next request addr 80000100.
- trap_redirect (trap_target 32'h80000800) and br_redirect (32'h80000040) in the same cycle in REQ -> next request addr 80000800.
- HOLD with inst_ready=0 for 5 cycles -> inst_valid held, inst/inst_pc stable, no new request; then inst_ready=1 -> request at pc+4.
- Redirect to 32'h80000200 in the same cycle as the HOLD handshake -> instruction consumed once; next request addr 80000200, not pc+4.
- Assert reset asynchronously during WAIT -> outputs reach reset values without a clock edge; after release, first request addr 80000000. With PERF_EN, counters read 0.

Source files
------------

// File: rtl/ysyx_22050854_fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package ysyx_22050854_fetch_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [PC_W-1:0] PC_STEP_DEF  = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ysyx_22050854_fetch_ctrl_redirect_sel.sv
// Redirect select: a CSR trap/return target wins over a branch target.
module ysyx_22050854_redirect_sel
    import ysyx_22050854_fetch_pkg::*;
(
    input  logic            br_redirect,
    input  logic [PC_W-1:0] br_target,
    input  logic            trap_redirect,
    input  logic [PC_W-1:0] trap_target,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_target
);

    always_comb begin
        redir_valid  = trap_redirect | br_redirect;
        redir_target = trap_redirect ? trap_target : br_target;
    end

endmodule

// File: rtl/ysyx_22050854_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, one outstanding imem request, squashes stale fetches.
// Optional perf counters enabled by YSYX_22050854_FETCH_PERF_EN.
module ysyx_22050854_fetch_ctrl
    import ysyx_22050854_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            br_redirect,
    input  logic [PC_W-1:0] br_target,
    input  logic            trap_redirect,
    input  logic [PC_W-1:0] trap_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            imem_resp_ready,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [PC_W-1:0] inst_pc,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] fetch_pc
`ifdef YSYX_22050854_FETCH_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_drop_cnt
`endif
);

    fetch_state_e    state, state_nxt;
    logic            drop, drop_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            cap;
    logic            redir_valid;
    logic [PC_W-1:0] redir_target;

    ysyx_22050854_redirect_sel u_redirect_sel (
        .br_redirect   (br_redirect),
        .br_target     (br_target),
        .trap_redirect (trap_redirect),
        .trap_target   (trap_target),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target)
    );

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        pc_nxt    = fetch_pc;
        cap       = 1'b0;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redir_valid) pc_nxt = redir_target;
                if (imem_req_ready) begin
                    state_nxt = WAIT;
                    // request already went out with the old PC
                    if (redir_valid) drop_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (redir_valid) pc_nxt = redir_target;
                if (imem_resp_valid) begin
                    drop_nxt  = 1'b0;
                    state_nxt = REQ;
                    if (!drop && !redir_valid) begin
                        cap       = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (redir_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redir_valid) begin
                    pc_nxt    = redir_target;
                    state_nxt = REQ;
                end else if (inst_ready) begin
                    pc_nxt    = fetch_pc + PC_STEP;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            drop     <= 1'b0;
            fetch_pc <= RESET_PC;
            inst_pc  <= '0;
            inst     <= '0;
        end else begin
            state    <= state_nxt;
            drop     <= drop_nxt;
            fetch_pc <= pc_nxt;
            if (cap) begin
                inst    <= imem_resp_data;
                inst_pc <= fetch_pc;
            end
        end
    end

    assign imem_req_valid  = (state == REQ);
    assign imem_req_addr   = fetch_pc;
    assign imem_resp_ready = (state == WAIT);
    assign inst_valid      = (state == HOLD);

`ifdef YSYX_22050854_FETCH_PERF_EN
    logic perf_take;
    logic perf_drop;

    assign perf_take = (state == HOLD) & inst_ready;
    assign perf_drop = ((state == WAIT) & imem_resp_valid & (drop | redir_valid))
                     | ((state == HOLD) & redir_valid & ~inst_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (perf_take) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (perf_drop) perf_drop_cnt  <= perf_drop_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050854_fetch_ctrl.sv
// Bench for the fetch sequencer: directed vector table, async reset, random run.
module tb_ysyx_22050854_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        br_redirect = 1'b0;
    logic [31:0] br_target = '0;
    logic        trap_redirect = 1'b0;
    logic [31:0] trap_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_ready;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic [31:0] fetch_pc;
`ifdef YSYX_22050854_FETCH_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_drop_cnt;
`endif

    ysyx_22050854_fetch_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .br_redirect     (br_redirect),
        .br_target       (br_target),
        .trap_redirect   (trap_redirect),
        .trap_target     (trap_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_ready (imem_resp_ready),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst            (inst),
        .fetch_pc        (fetch_pc)
`ifdef YSYX_22050854_FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_drop_cnt   (perf_drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    localparam logic [31:0] A = 32'h8000_0000;

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // st: 0 idle, 1 request, 2 wait, 3 hold; rk: 0 none, 1 br, 2 trap, 3 both
    typedef struct {
        int          st;
        logic [31:0] fpc;
        logic [31:0] ipc;
        logic [31:0] ins;
        logic        rqr;
        logic        rsv;
        logic [31:0] rdat;
        logic        ir;
        int          rk;
        logic [31:0] tgt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int st, logic [31:0] fpc, logic [31:0] ipc,
                                logic [31:0] ins, logic rqr, logic rsv,
                                logic [31:0] rdat, logic ir, int rk,
                                logic [31:0] tgt);
        vec_t v;
        v.st = st; v.fpc = fpc; v.ipc = ipc; v.ins = ins;
        v.rqr = rqr; v.rsv = rsv; v.rdat = rdat; v.ir = ir;
        v.rk = rk; v.tgt = tgt;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        imem_req_ready  = v.rqr;
        imem_resp_valid = v.rsv;
        imem_resp_data  = v.rdat;
        inst_ready      = v.ir;
        br_redirect     = (v.rk == 1) || (v.rk == 3);
        trap_redirect   = (v.rk >= 2);
        case (v.rk)
            1: begin br_target = v.tgt; trap_target = ~v.tgt; end
            2: begin trap_target = v.tgt; br_target = ~v.tgt; end
            3: begin trap_target = v.tgt; br_target = v.tgt ^ 32'h0000_0840; end
            default: begin br_target = '0; trap_target = '0; end
        endcase
    endtask

    task automatic chk_row(input int i, input vec_t v);
        chk($sformatf("row%0d.req_valid", i), 64'(imem_req_valid), 64'(v.st == 1));
        chk($sformatf("row%0d.resp_ready", i), 64'(imem_resp_ready), 64'(v.st == 2));
        chk($sformatf("row%0d.inst_valid", i), 64'(inst_valid), 64'(v.st == 3));
        chk($sformatf("row%0d.req_addr", i), 64'(imem_req_addr), 64'(v.fpc));
        chk($sformatf("row%0d.fetch_pc", i), 64'(fetch_pc), 64'(v.fpc));
        chk($sformatf("row%0d.inst_pc", i), 64'(inst_pc), 64'(v.ipc));
        chk($sformatf("row%0d.inst", i), 64'(inst), 64'(v.ins));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req_valid"}, 64'(imem_req_valid), 64'd0);
        chk({tag, ".resp_ready"}, 64'(imem_resp_ready), 64'd0);
        chk({tag, ".inst_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, ".inst_pc"}, 64'(inst_pc), 64'd0);
        chk({tag, ".inst"}, 64'(inst), 64'd0);
        chk({tag, ".fetch_pc"}, 64'(fetch_pc), 64'(A));
`ifdef YSYX_22050854_FETCH_PERF_EN
        chk({tag, ".perf_fetch"}, perf_fetch_cnt, 64'd0);
        chk({tag, ".perf_drop"}, perf_drop_cnt, 64'd0);
`endif
    endtask

    logic        busy;
    int          dly;
    logic [31:0] raddr;
    logic [31:0] mpc;
    int          delivered;
    logic        resp_hs;

    initial begin
        tbl.push_back(mk(0, A, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, A, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, A, 0, 0, 1, 1, 32'h0000_0413, 1, 0, 0));
        tbl.push_back(mk(3, A, A, 32'h413, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, A + 4, A, 32'h413, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, A + 4, A, 32'h413, 0, 0, 0, 1, 1, 32'h8000_0100));
        tbl.push_back(mk(2, 32'h8000_0100, A, 32'h413, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 32'h8000_0100, A, 32'h413, 0, 1, 32'hDEAD_BEEF, 1, 0, 0));
        tbl.push_back(mk(1, 32'h8000_0100, A, 32'h413, 0, 0, 0, 1, 3, 32'h8000_0800));
        tbl.push_back(mk(1, 32'h8000_0800, A, 32'h413, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 32'h8000_0800, A, 32'h413, 1, 1, 32'h1111_1111, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(3, 32'h8000_0800, 32'h8000_0800, 32'h1111_1111, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3, 32'h8000_0800, 32'h8000_0800, 32'h1111_1111, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h8000_0804, 32'h8000_0800, 32'h1111_1111, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 32'h8000_0804, 32'h8000_0800, 32'h1111_1111, 1, 1, 32'h2222_2222, 1, 0, 0));
        tbl.push_back(mk(3, 32'h8000_0804, 32'h8000_0804, 32'h2222_2222, 0, 0, 0, 1, 1, 32'h8000_0200));
        tbl.push_back(mk(1, 32'h8000_0200, 32'h8000_0804, 32'h2222_2222, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h8000_0200, 32'h8000_0804, 32'h2222_2222, 1, 0, 0, 1, 1, 32'h8000_0300));
        tbl.push_back(mk(2, 32'h8000_0300, 32'h8000_0804, 32'h2222_2222, 1, 1, 32'h3333_3333, 1, 0, 0));
        tbl.push_back(mk(1, 32'h8000_0300, 32'h8000_0804, 32'h2222_2222, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 32'h8000_0300, 32'h8000_0804, 32'h2222_2222, 1, 1, 32'h4444_4444, 0, 0, 0));
        tbl.push_back(mk(3, 32'h8000_0300, 32'h8000_0300, 32'h4444_4444, 0, 0, 0, 0, 1, 32'h8000_0400));
        tbl.push_back(mk(1, 32'h8000_0400, 32'h8000_0300, 32'h4444_4444, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 32'h8000_0400, 32'h8000_0300, 32'h4444_4444, 0, 0, 0, 1, 1, 32'h8000_0500));
        tbl.push_back(mk(2, 32'h8000_0500, 32'h8000_0300, 32'h4444_4444, 0, 0, 0, 1, 2, 32'h8000_0600));
        tbl.push_back(mk(2, 32'h8000_0600, 32'h8000_0300, 32'h4444_4444, 0, 1, 32'h5555_5555, 1, 0, 0));
        tbl.push_back(mk(1, 32'h8000_0600, 32'h8000_0300, 32'h4444_4444, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 32'h8000_0600, 32'h8000_0300, 32'h4444_4444, 1, 1, 32'h6666_6666, 1, 0, 0));
        tbl.push_back(mk(3, 32'h8000_0600, 32'h8000_0600, 32'h6666_6666, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h8000_0604, 32'h8000_0600, 32'h6666_6666, 0, 0, 0, 0, 0, 0));

        // reset values while reset is held
        @(negedge clock);
        chk_reset_vals("reset");
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) begin
            chk_row(i, tbl[i]);
            apply(tbl[i]);
            @(negedge clock);
        end

`ifdef YSYX_22050854_FETCH_PERF_EN
        chk("perf_fetch_after_table", perf_fetch_cnt, 64'd4);
        chk("perf_drop_after_table", perf_drop_cnt, 64'd4);
`endif

        // asynchronous reset in the middle of WAIT
        imem_req_ready = 1'b1;
        @(negedge clock);
        imem_req_ready = 1'b0;
        chk("pre_reset.resp_ready", 64'(imem_resp_ready), 64'd1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset.req_valid", 64'(imem_req_valid), 64'd1);
        chk("post_reset.req_addr", 64'(imem_req_addr), 64'(A));

        // random run against an architectural next-PC model
        busy = 1'b0;
        dly = 0;
        raddr = '0;
        mpc = A;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clock);
            chk("rand.fetch_pc", 64'(fetch_pc), 64'(mpc));
            if (inst_valid) begin
                chk("rand.inst_pc", 64'(inst_pc), 64'(mpc));
                chk("rand.inst", 64'(inst), 64'(memf(mpc)));
            end
            imem_req_ready  = ($urandom_range(0, 9) < 7);
            inst_ready      = ($urandom_range(0, 3) != 0);
            imem_resp_valid = busy && (dly == 0);
            imem_resp_data  = imem_resp_valid ? memf(raddr) : $urandom();
            br_redirect     = ($urandom_range(0, 11) == 0);
            trap_redirect   = ($urandom_range(0, 19) == 0);
            br_target       = ($urandom() & 32'h0000_FFFC) | A;
            trap_target     = ($urandom() & 32'h0000_FFFC) | A;

            resp_hs = imem_resp_valid && imem_resp_ready;
            if (resp_hs) busy = 1'b0;
            else if (busy && dly > 0) dly--;
            if (imem_req_valid && imem_req_ready) begin
                chk("rand.req_addr", 64'(imem_req_addr), 64'(mpc));
                chk("rand.one_outstanding", 64'(busy), 64'd0);
                busy  = 1'b1;
                raddr = imem_req_addr;
                dly   = $urandom_range(0, 3);
            end
            if (inst_valid && inst_ready) delivered++;
            if (trap_redirect) mpc = trap_target;
            else if (br_redirect) mpc = br_target;
            else if (inst_valid && inst_ready) mpc = mpc + 32'd4;
        end
        chk("rand.progress", 64'(delivered > 100), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
